// File: rtl/seg_scan_mux.sv
// Six-digit multiplexed seven-segment scanner with frame snapshots, anti-ghost blanking,
// 16-level brightness PWM and colon output. All outputs are registered.
module seg_scan_mux #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] H1,
  input  logic [6:0] H2,
  input  logic [6:0] M1,
  input  logic [6:0] M2,
  input  logic [6:0] S1,
  input  logic [6:0] S2,
  input  logic [3:0] bright,
  input  logic       colon_en,
  output logic [6:0] seg_out,
  output logic       dp_n,
  output logic [5:0] an_n,
  output logic       frame_tick
);

  localparam int unsigned     CntW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] SlotLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYC);

  logic [CntW-1:0] slot_q, slot_d;
  logic [2:0]      digit_q, digit_d;
  logic [3:0]      pwm_q, pwm_d;
  logic [5:0][6:0] pat_q;
  logic [3:0]      bright_q;
  logic            colon_q;

  logic            slot_end, capture, blank, lit;
  logic [6:0]      cur_pat, seg_d;
  logic [5:0]      an_d;
  logic            dp_d;

  // Slot / digit sequencing and PWM counter next state.
  always_comb begin
    slot_end = (slot_q == SlotLast);
    capture  = slot_end && (digit_q == 3'd5);
    blank    = (slot_q < BlankEnd);
    slot_d   = slot_end ? '0 : slot_q + CntW'(1);
    digit_d  = digit_q;
    if (slot_end) begin
      digit_d = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
    end
    // PWM restarts every slot so each digit gets the same duty pattern.
    pwm_d = (slot_end || blank) ? 4'd0 : pwm_q + 4'd1;
  end

  // Display decode from shadows; registered below so outputs lag state by one cycle.
  always_comb begin
    lit = !blank && (pwm_q <= bright_q);
    unique case (digit_q)
      3'd0:    cur_pat = pat_q[0];
      3'd1:    cur_pat = pat_q[1];
      3'd2:    cur_pat = pat_q[2];
      3'd3:    cur_pat = pat_q[3];
      3'd4:    cur_pat = pat_q[4];
      3'd5:    cur_pat = pat_q[5];
      default: cur_pat = 7'h7F;
    endcase
    seg_d = 7'h7F;
    an_d  = 6'h3F;
    dp_d  = 1'b1;
    if (lit) begin
      seg_d = cur_pat;
      an_d  = ~(6'b1 << digit_q);
      dp_d  = ~(colon_q && ((digit_q == 3'd1) || (digit_q == 3'd3)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      digit_q <= 3'd0;
      pwm_q   <= 4'd0;
    end else begin
      slot_q  <= slot_d;
      digit_q <= digit_d;
      pwm_q   <= pwm_d;
    end
  end

  // Shadows only change at the frame boundary, so a frame is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q    <= {6{7'h7F}};
      bright_q <= 4'd0;
      colon_q  <= 1'b0;
    end else if (capture) begin
      pat_q    <= {S2, S1, M2, M1, H2, H1};
      bright_q <= bright;
      colon_q  <= colon_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= 7'h7F;
      dp_n       <= 1'b1;
      an_n       <= 6'h3F;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= seg_d;
      dp_n       <= dp_d;
      an_n       <= an_d;
      frame_tick <= capture;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux (SCAN_DIV=20, BLANK_CYC=4) against a frame-arithmetic
// reference model plus scenario-specific expectations.
module tb_seg_scan_mux;

  localparam int Div   = 20;
  localparam int Blank = 4;
  localparam int Frame = 6 * Div;

  localparam logic [6:0] P0 = 7'b0000001;
  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100;
  localparam logic [6:0] P9 = 7'b0000100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] H1, H2, M1, M2, S1, S2;
  logic [3:0] bright;
  logic       colon_en;
  logic [6:0] seg_out;
  logic       dp_n;
  logic [5:0] an_n;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;

  seg_scan_mux #(.SCAN_DIV(Div), .BLANK_CYC(Blank)) dut (
    .clk(clk), .rst_n(rst_n),
    .H1(H1), .H2(H2), .M1(M1), .M2(M2), .S1(S1), .S2(S2),
    .bright(bright), .colon_en(colon_en),
    .seg_out(seg_out), .dp_n(dp_n), .an_n(an_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: cyc = clock edges since reset release; the displayed frame's values are
  // whatever the inputs held at the end of the previous frame.
  int         cyc;
  logic [6:0] snap_pat [6];
  logic [3:0] snap_bright;
  logic       snap_colon;
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic [5:0] exp_an;
  logic       exp_tick;

  function automatic logic [13:0] model_out(int k);
    int s, d;
    logic on;
    s  = k % Div;
    d  = (k / Div) % 6;
    on = (s >= Blank) && (((s - Blank) % 16) <= int'(snap_bright));
    if (!on) return {7'h7F, 1'b1, 6'h3F};
    return {snap_pat[d], !(snap_colon && (d == 1 || d == 3)), ~(6'b1 << d)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int i = 0; i < 6; i++) snap_pat[i] <= 7'h7F;
      snap_bright <= 4'd0;
      snap_colon  <= 1'b0;
      {exp_seg, exp_dp, exp_an} <= {7'h7F, 1'b1, 6'h3F};
      exp_tick <= 1'b0;
    end else begin
      {exp_seg, exp_dp, exp_an} <= model_out(cyc);
      exp_tick <= (cyc % Frame == Frame - 1);
      if (cyc % Frame == Frame - 1) begin
        snap_pat[0] <= H1; snap_pat[1] <= H2; snap_pat[2] <= M1;
        snap_pat[3] <= M2; snap_pat[4] <= S1; snap_pat[5] <= S2;
        snap_bright <= bright;
        snap_colon  <= colon_en;
      end
      cyc <= cyc + 1;
    end
  end

  // Advance to the next frame boundary (capture edge just taken).
  task automatic align_frame();
    int guard = 0;
    @(negedge clk);
    while ((cyc % Frame) != 0 && guard < 2 * Frame) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    H1 = P0; H2 = P9; M1 = P4; M2 = P1; S1 = P0; S2 = P3;
    bright = 4'd15; colon_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({seg_out, an_n, dp_n, frame_tick} !== {7'h7F, 6'h3F, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL reset_hold: got seg=%h an=%h dp=%b tick=%b want 7f 3f 1 0",
                 seg_out, an_n, dp_n, frame_tick);
      end
    end
    rst_n = 1'b1;
    for (int n = 1; n <= Frame; n++) begin
      @(negedge clk);
      total++;
      if (seg_out !== 7'h7F) begin
        bad++;
        $display("FAIL first_frame_seg n=%0d: got %h want 7f", n, seg_out);
      end
      total++;
      if (frame_tick !== (n == Frame)) begin
        bad++;
        $display("FAIL first_tick n=%0d: got %b want %b", n, frame_tick, n == Frame);
      end
      total++;
      if ({seg_out, dp_n, an_n, frame_tick} !== {exp_seg, exp_dp, exp_an, exp_tick}) begin
        bad++;
        $display("FAIL reset_model n=%0d: got %h/%b/%h/%b want %h/%b/%h/%b", n, seg_out, dp_n,
                 an_n, frame_tick, exp_seg, exp_dp, exp_an, exp_tick);
      end
    end
  endtask

  task automatic test_full_bright();
    logic [5:0] an_tab [6];
    logic [6:0] pat_tab [6];
    int s, d;
    an_tab  = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    pat_tab = '{P0, P9, P4, P1, P0, P3};
    for (int i = 0; i < Frame; i++) begin
      @(negedge clk);
      s = i % Div;
      d = i / Div;
      total++;
      if (an_n !== ((s < Blank) ? 6'h3F : an_tab[d]) ||
          seg_out !== ((s < Blank) ? 7'h7F : pat_tab[d])) begin
        bad++;
        $display("FAIL full_bright d=%0d s=%0d: got an=%h seg=%b want an=%h seg=%b", d, s,
                 an_n, seg_out, (s < Blank) ? 6'h3F : an_tab[d],
                 (s < Blank) ? 7'h7F : pat_tab[d]);
      end
      total++;
      if ({seg_out, dp_n, an_n, frame_tick} !== {exp_seg, exp_dp, exp_an, exp_tick}) begin
        bad++;
        $display("FAIL full_bright_model i=%0d: got %h/%b/%h/%b want %h/%b/%h/%b", i, seg_out,
                 dp_n, an_n, frame_tick, exp_seg, exp_dp, exp_an, exp_tick);
      end
    end
  endtask

  task automatic test_pwm();
    int s, lit_cnt, want_cnt;
    for (int pass = 0; pass < 2; pass++) begin
      bright   = (pass == 0) ? 4'd3 : 4'd0;
      want_cnt = (pass == 0) ? 4 : 1;
      align_frame();
      lit_cnt = 0;
      for (int i = 0; i < Frame; i++) begin
        @(negedge clk);
        s = i % Div;
        if (an_n != 6'h3F) lit_cnt++;
        total++;
        if ((an_n != 6'h3F) !== (s >= Blank && s < Blank + want_cnt)) begin
          bad++;
          $display("FAIL pwm_window b=%0d s=%0d: got an=%h want lit=%b", bright, s, an_n,
                   s >= Blank && s < Blank + want_cnt);
        end
        if (s == Div - 1) begin
          total++;
          if (lit_cnt != want_cnt) begin
            bad++;
            $display("FAIL pwm_count b=%0d: got %0d want %0d", bright, lit_cnt, want_cnt);
          end
          lit_cnt = 0;
        end
      end
    end
  endtask

  task automatic test_snapshot();
    int s, d;
    bright = 4'd15;
    M2 = P1;
    align_frame();
    for (int i = 0; i < 2 * Frame; i++) begin
      @(negedge clk);
      s = i % Div;
      d = (i / Div) % 6;
      if (i == 45) M2 = P2;
      if (d == 3 && s >= Blank) begin
        total++;
        if (seg_out !== ((i < Frame) ? P1 : P2)) begin
          bad++;
          $display("FAIL snapshot i=%0d: got %b want %b", i, seg_out, (i < Frame) ? P1 : P2);
        end
      end
      total++;
      if ({seg_out, dp_n, an_n, frame_tick} !== {exp_seg, exp_dp, exp_an, exp_tick}) begin
        bad++;
        $display("FAIL snapshot_model i=%0d: got %h/%b/%h/%b want %h/%b/%h/%b", i, seg_out,
                 dp_n, an_n, frame_tick, exp_seg, exp_dp, exp_an, exp_tick);
      end
    end
  endtask

  task automatic test_colon();
    int s, d;
    colon_en = 1'b1;
    align_frame();
    for (int i = 0; i < Frame; i++) begin
      @(negedge clk);
      s = i % Div;
      d = i / Div;
      total++;
      if (dp_n !== !(s >= Blank && (d == 1 || d == 3))) begin
        bad++;
        $display("FAIL colon d=%0d s=%0d: got dp=%b want %b", d, s, dp_n,
                 !(s >= Blank && (d == 1 || d == 3)));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4 * Frame; i++) begin
      @(negedge clk);
      total++;
      if ({seg_out, dp_n, an_n, frame_tick} !== {exp_seg, exp_dp, exp_an, exp_tick}) begin
        bad++;
        $display("FAIL random_model cyc=%0d: got %h/%b/%h/%b want %h/%b/%h/%b", cyc, seg_out,
                 dp_n, an_n, frame_tick, exp_seg, exp_dp, exp_an, exp_tick);
      end
      if ($urandom_range(0, 29) == 0) begin
        H1 = 7'($urandom); H2 = 7'($urandom); M1 = 7'($urandom);
        M2 = 7'($urandom); S1 = 7'($urandom); S2 = 7'($urandom);
        bright   = 4'($urandom);
        colon_en = 1'($urandom);
      end
    end
  endtask

  task automatic test_mid_reset();
    bright = 4'd15;
    align_frame();
    repeat (2 * Div + 10) @(negedge clk);
    total++;
    if (an_n !== 6'h3B) begin
      bad++;
      $display("FAIL mid_reset_pre: got an=%h want 3b", an_n);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({an_n, seg_out, dp_n, frame_tick} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset_async: got an=%h seg=%h dp=%b tick=%b want 3f 7f 1 0",
               an_n, seg_out, dp_n, frame_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= Div; n++) begin
      @(negedge clk);
      total++;
      if (an_n !== ((n == Blank + 1) ? 6'h3E : 6'h3F) || seg_out !== 7'h7F) begin
        bad++;
        $display("FAIL mid_reset_restart n=%0d: got an=%h seg=%h want an=%h seg=7f", n, an_n,
                 seg_out, (n == Blank + 1) ? 6'h3E : 6'h3F);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_bright();
    test_pwm();
    test_snapshot();
    test_colon();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
